// File: rtl/mem_dispatch_pkg.sv
// Shared types and helpers for the two-lane dispatch queue.
package mem_dispatch_pkg;

    // Lane identifier; also the encoding of the last-lane register
    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_sel_t;

    // Occupancy counter width: must represent 0..DEPTH inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dispatch_lane_fifo.sv
// One dispatch lane: circular storage with flush and optional fall-through.
module dispatch_lane_fifo
    import mem_dispatch_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b1,
    parameter type         dtype        = logic [31:0]
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  dtype                          data_i,
    input  logic                          pop_i,
    output dtype                          data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    dtype            r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    logic            w_ft;
    logic            w_ft_take;
    logic            w_pop;
    logic            w_wr;

    // Head presentation, bypass detection and the effective read/write strobes
    always_comb begin
        w_ft      = FALL_THROUGH && (r_count == '0) && push_i;
        w_ft_take = w_ft && pop_i && !flush_i;
        w_pop     = pop_i && !flush_i && (r_count != '0);
        w_wr      = push_i && !w_ft_take;
        empty_o   = (r_count == '0) && !w_ft;
        data_o    = w_ft ? data_i : r_mem[r_rd];
    end

    assign full_o  = (r_count == CW'(DEPTH));
    assign count_o = r_count;

    // Pointer and occupancy bookkeeping; reset and flush both clear the lane
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr] <= data_i;
    end

endmodule

// File: rtl/dual_fifo_dispatch.sv
// Round-robin steering of one producer stream across two independent lanes.
module dual_fifo_dispatch
    import mem_dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  dtype                          data_i,
    input  logic                          push_i,
    output logic                          full_o,
    input  logic                          flush_i1,
    input  logic                          flush_i2,
    output dtype                          data_o1,
    input  logic                          pop_i1,
    output logic                          empty_o1,
    output logic                          full_o1,
    output logic [cnt_width(DEPTH)-1:0]   count_o1,
    output dtype                          data_o2,
    input  logic                          pop_i2,
    output logic                          empty_o2,
    output logic                          full_o2,
    output logic [cnt_width(DEPTH)-1:0]   count_o2
);

    lane_sel_t r_last_lane;

    logic      w_avail1;
    logic      w_avail2;
    lane_sel_t w_chosen;
    logic      w_accept;
    logic      w_push1;
    logic      w_push2;

    // Prefer the lane not used last; fall back to the other when unavailable
    always_comb begin
        w_avail1 = !full_o1 && !flush_i1;
        w_avail2 = !full_o2 && !flush_i2;
        if (r_last_lane == LANE2) begin
            w_chosen = w_avail1 ? LANE1 : LANE2;
        end else begin
            w_chosen = w_avail2 ? LANE2 : LANE1;
        end
        full_o   = !w_avail1 && !w_avail2;
        w_accept = push_i && !full_o;
        w_push1  = w_accept && (w_chosen == LANE1);
        w_push2  = w_accept && (w_chosen == LANE2);
    end

    // Remember which lane took the last accepted word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_lane <= LANE2;
        end else if (w_accept) begin
            r_last_lane <= w_chosen;
        end
    end

    dispatch_lane_fifo #(
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH),
        .dtype        (dtype)
    ) u_lane1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i1),
        .push_i  (w_push1),
        .data_i  (data_i),
        .pop_i   (pop_i1),
        .data_o  (data_o1),
        .empty_o (empty_o1),
        .full_o  (full_o1),
        .count_o (count_o1)
    );

    dispatch_lane_fifo #(
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH),
        .dtype        (dtype)
    ) u_lane2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i2),
        .push_i  (w_push2),
        .data_i  (data_i),
        .pop_i   (pop_i2),
        .data_o  (data_o2),
        .empty_o (empty_o2),
        .full_o  (full_o2),
        .count_o (count_o2)
    );

endmodule

// File: tb/tb_dual_fifo_dispatch.sv
// Directed bench for dual_fifo_dispatch with a queue-based reference model.
module tb_dual_fifo_dispatch;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          push_i = 1'b0;
    logic          flush_i1 = 1'b0;
    logic          flush_i2 = 1'b0;
    logic          pop_i1 = 1'b0;
    logic          pop_i2 = 1'b0;
    logic          full_o;
    logic [DW-1:0] data_o1;
    logic [DW-1:0] data_o2;
    logic          empty_o1;
    logic          empty_o2;
    logic          full_o1;
    logic          full_o2;
    logic [2:0]    count_o1;
    logic [2:0]    count_o2;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    dual_fifo_dispatch #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DP),
        .FALL_THROUGH (1'b1)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .push_i   (push_i),
        .full_o   (full_o),
        .flush_i1 (flush_i1),
        .flush_i2 (flush_i2),
        .data_o1  (data_o1),
        .pop_i1   (pop_i1),
        .empty_o1 (empty_o1),
        .full_o1  (full_o1),
        .count_o1 (count_o1),
        .data_o2  (data_o2),
        .pop_i2   (pop_i2),
        .empty_o2 (empty_o2),
        .full_o2  (full_o2),
        .count_o2 (count_o2)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one queue per lane plus the lane that took the last word
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    int            last = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every cycle mid-low-phase, then advances the model
    always @(negedge clk_i) begin
        bit av1, av2, efull, acc, ft1, ft2, e1, e2;
        int ch;
        #2;
        av1   = (q1.size() < DP) && !flush_i1;
        av2   = (q2.size() < DP) && !flush_i2;
        efull = !av1 && !av2;
        if (last == 1) ch = av1 ? 0 : 1;
        else           ch = av2 ? 1 : 0;
        acc = push_i && !efull;
        ft1 = acc && ch == 0 && q1.size() == 0;
        ft2 = acc && ch == 1 && q2.size() == 0;
        e1  = q1.size() == 0 && !ft1;
        e2  = q2.size() == 0 && !ft2;
        if (armed) begin
            chk("m_full", full_o, efull);
            chk("m_empty1", empty_o1, e1);
            chk("m_empty2", empty_o2, e2);
            chk("m_count1", count_o1, q1.size());
            chk("m_count2", count_o2, q2.size());
            chk("m_full1", full_o1, q1.size() == DP);
            chk("m_full2", full_o2, q2.size() == DP);
            if (!e1) chk("m_data1", data_o1, ft1 ? data_i : q1[0]);
            if (!e2) chk("m_data2", data_o2, ft2 ? data_i : q2[0]);
        end
        if (rst_i) begin
            q1.delete(); q2.delete(); last = 1;
        end else begin
            if (flush_i1) q1.delete();
            else if (!(ft1 && pop_i1)) begin
                if (pop_i1 && q1.size() > 0) void'(q1.pop_front());
                if (acc && ch == 0) q1.push_back(data_i);
            end
            if (flush_i2) q2.delete();
            else if (!(ft2 && pop_i2)) begin
                if (pop_i2 && q2.size() > 0) void'(q2.pop_front());
                if (acc && ch == 1) q2.push_back(data_i);
            end
            if (acc) last = ch;
        end
    end

    // Drive one cycle of inputs; returns mid-cycle, after the model compare
    task automatic cyc(input bit rst, input bit push, input logic [DW-1:0] d,
                       input bit p1, input bit p2, input bit f1, input bit f2);
        @(negedge clk_i);
        rst_i = rst; push_i = push; data_i = d;
        pop_i1 = p1; pop_i2 = p2; flush_i1 = f1; flush_i2 = f2;
        #3;
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cyc(0, 1, d, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and base state
        cyc(1, 0, '0, 0, 0, 0, 0);
        armed = 1'b1;
        idle();
        chk("rst_empty1", empty_o1, 1);
        chk("rst_empty2", empty_o2, 1);
        chk("rst_count1", count_o1, 0);
        chk("rst_full", full_o, 0);

        // Alternation: A,C to lane 1 and B,D to lane 2
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        idle();
        chk("t1_count1", count_o1, 2);
        chk("t1_count2", count_o2, 2);
        chk("t1_head1", data_o1, 32'hA);
        chk("t1_head2", data_o2, 32'hB);

        // Fill both lanes, reject a ninth push, then free a lane-2 slot
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i));
        idle();
        chk("t2_full", full_o, 1);
        push(32'hBAD);
        idle();
        chk("t2_count1", count_o1, 4);
        chk("t2_count2", count_o2, 4);
        cyc(0, 0, '0, 0, 1, 0, 0);
        idle();
        chk("t2_full_clr", full_o, 0);
        push(32'h200);
        idle();
        chk("t2_redir", count_o2, 4);

        // Redirect while lane 1 full and lane 2 was used last
        cyc(1, 0, '0, 0, 0, 0, 0);
        push(32'h1); push(32'h2); push(32'h3); push(32'h4);
        cyc(0, 1, 32'h5, 0, 1, 0, 0);
        cyc(0, 1, 32'h6, 0, 1, 0, 0);
        push(32'h7);
        cyc(0, 1, 32'h8, 0, 1, 0, 0);
        idle();
        chk("t3_pre1", count_o1, 4);
        chk("t3_pre2", count_o2, 1);
        chk("t3_head2", data_o2, 32'h8);
        push(32'h11);
        idle();
        chk("t3_count2", count_o2, 2);
        push(32'h12);
        idle();
        chk("t3_stay2", count_o2, 3);

        // Fall-through with same-cycle pop consumes the word unstored
        cyc(1, 0, '0, 0, 0, 0, 0);
        cyc(0, 1, 32'h55, 1, 0, 0, 0);
        chk("t4_ft_data", data_o1, 32'h55);
        chk("t4_ft_empty", empty_o1, 0);
        idle();
        chk("t4_count1", count_o1, 0);
        push(32'h66);
        idle();
        chk("t4_next2", count_o2, 1);
        chk("t4_next1", count_o1, 0);

        // Flush of lane 1 steers the concurrent push to lane 2
        cyc(1, 0, '0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) push(32'(i));
        cyc(0, 1, 32'h77, 0, 0, 1, 0);
        idle();
        chk("t5_count1", count_o1, 0);
        chk("t5_empty1", empty_o1, 1);
        chk("t5_count2", count_o2, 4);
        cyc(0, 1, 32'h78, 0, 0, 1, 1);
        chk("t5_both_full", full_o, 1);
        idle();
        chk("t5_both_zero", count_o2, 0);

        // Reset wins over push and pop
        cyc(1, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(32'h40 + 32'(i));
        cyc(1, 1, 32'hEE, 1, 1, 0, 0);
        idle();
        chk("t6_count1", count_o1, 0);
        chk("t6_empty2", empty_o2, 1);
        push(32'h99);
        idle();
        chk("t6_lane1", count_o1, 1);
        chk("t6_head1", data_o1, 32'h99);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
